tpsram_fifo_ctrl: RTL and testbench

// Synchronous FIFO controller that sequences one external 64x20 two-port SRAM (1-cycle read latency).

---
 rtl/tpsram_fifo_pkg.sv | 17 +
 rtl/tpsram_fifo_outbuf.sv | 66 ++++++
 rtl/tpsram_fifo_ctrl.sv | 149 ++++++++++++++
 tb/tb_tpsram_fifo_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpsram_fifo_pkg.sv
// Shared defaults and the output-stage occupancy encoding for the two-port SRAM FIFO controller.
package tpsram_fifo_pkg;

  localparam int DATA_W_DEF    = 20;
  localparam int ADDR_W_DEF    = 6;
  localparam int DEPTH_DEF     = 1 << ADDR_W_DEF;
  localparam int AFULL_TH_DEF  = 56;
  localparam int AEMPTY_TH_DEF = 8;

  // Encoded so the enum value equals the number of words held.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/tpsram_fifo_outbuf.sv
// Two-entry output stage: absorbs SRAM read data one cycle after issue and presents a registered head word.
module tpsram_fifo_outbuf
  import tpsram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] head_o,
  output logic              valid_o,
  output occ_t              occ_o
);

  occ_t              occ_q;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;

  // The issue logic upstream never lets occupancy plus in-flight reads exceed two,
  // so a push into TWO only ever arrives together with a pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else if (flush_i) begin
      occ_q <= OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push_i) begin
            head_q <= push_data_i;
            occ_q  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({push_i, pop_i})
            2'b11: head_q <= push_data_i;
            2'b10: begin
              tail_q <= push_data_i;
              occ_q  <= OCC_TWO;
            end
            2'b01: occ_q <= OCC_EMPTY;
            default: ;
          endcase
        end
        OCC_TWO: begin
          if (pop_i) begin
            head_q <= tail_q;
            if (push_i) tail_q <= push_data_i;
            else        occ_q  <= OCC_ONE;
          end
        end
        default: occ_q <= OCC_EMPTY;
      endcase
    end
  end

  assign head_o  = head_q;
  assign valid_o = (occ_q != OCC_EMPTY);
  assign occ_o   = occ_q;

endmodule

// File: rtl/tpsram_fifo_ctrl.sv
// FIFO controller around an external 1-cycle-latency two-port SRAM with first-word-fall-through streams.
module tpsram_fifo_ctrl
  import tpsram_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AFULL_TH  = AFULL_TH_DEF,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              WR_VALID,
  output logic              WR_READY,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  input  logic              RD_READY,
  input  logic              FLUSH,
  output logic [ADDR_W:0]   COUNT,
  output logic              AFULL,
  output logic              AEMPTY,
  output logic              RAM_W_EN,
  output logic [ADDR_W-1:0] RAM_W_ADDR,
  output logic [DATA_W-1:0] RAM_W_DATA,
  output logic              RAM_R_EN,
  output logic [ADDR_W-1:0] RAM_R_ADDR,
  input  logic [DATA_W-1:0] RAM_R_DATA,
  output occ_t              dbg_occ_o
);

  localparam int                CW       = ADDR_W + 1;
  localparam logic [ADDR_W:0]   DEPTH_C  = CW'(1 << ADDR_W);
  localparam logic [ADDR_W:0]   AFULL_C  = CW'(AFULL_TH);
  localparam logic [ADDR_W:0]   AEMPTY_C = CW'(AEMPTY_TH);
  localparam logic [ADDR_W:0]   CNT_ONE  = CW'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  // Handshake rules: a word moves on a port exactly in a cycle where valid and ready are
  // both high at the rising edge; valid never depends on ready on the same port.
  logic              ready_q;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              inflight_q;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;

  logic              wr_ready;
  logic              w_en;
  logic              r_en;
  logic              pop;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  occ_t              occ;
  logic [1:0]        occ_n;
  logic [2:0]        slots_used;

  assign occ_n = occ;

  always_comb begin
    wr_ready   = ready_q & (ram_cnt_q < DEPTH_C) & ~FLUSH;
    w_en       = WR_VALID & wr_ready;
    pop        = rd_valid & RD_READY;
    // Output slots that will be occupied after this edge if no new read is issued.
    slots_used = {1'b0, occ_n} + {2'b00, inflight_q} - {2'b00, pop};
    // ram_cnt excludes the word being written this cycle, so rptr never meets wptr here.
    r_en       = (ram_cnt_q != '0) & (slots_used < 3'd2) & ~FLUSH;

    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ram_cnt_d = ram_cnt_q;
    count_d   = count_q;

    if (FLUSH) begin
      wptr_d    = '0;
      rptr_d    = '0;
      ram_cnt_d = '0;
      count_d   = '0;
    end else begin
      if (w_en) wptr_d = wptr_q + PTR_ONE;
      if (r_en) rptr_d = rptr_q + PTR_ONE;
      case ({w_en, r_en})
        2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
        2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
        default: ram_cnt_d = ram_cnt_q;
      endcase
      case ({w_en, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ready_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
    end else begin
      ready_q    <= 1'b1;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      count_q    <= count_d;
      inflight_q <= r_en;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
    end
  end

  // Read data landing during a flush cycle is dropped because flush wins over push.
  tpsram_fifo_outbuf #(
    .DATA_W (DATA_W)
  ) u_outbuf (
    .clk_i       (CLK),
    .rst_ni      (RESETN),
    .push_i      (inflight_q),
    .push_data_i (RAM_R_DATA),
    .pop_i       (pop),
    .flush_i     (FLUSH),
    .head_o      (rd_data),
    .valid_o     (rd_valid),
    .occ_o       (occ)
  );

  assign WR_READY   = wr_ready;
  assign RD_DATA    = rd_data;
  assign RD_VALID   = rd_valid;
  assign COUNT      = count_q;
  assign AFULL      = afull_q;
  assign AEMPTY     = aempty_q;
  assign RAM_W_EN   = w_en;
  assign RAM_W_ADDR = wptr_q;
  assign RAM_W_DATA = WR_DATA;
  assign RAM_R_EN   = r_en;
  assign RAM_R_ADDR = rptr_q;
  assign dbg_occ_o  = occ;

endmodule

// File: tb/tb_tpsram_fifo_ctrl.sv
// Bench for tpsram_fifo_ctrl: SRAM model, directed phases, and a negedge scoreboard monitor.
module tb_tpsram_fifo_ctrl;
  import tpsram_fifo_pkg::*;

  localparam int DW = 20;
  localparam int AW = 6;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic [DW-1:0] WR_DATA;
  logic          WR_VALID;
  logic          WR_READY;
  logic [DW-1:0] RD_DATA;
  logic          RD_VALID;
  logic          RD_READY;
  logic          FLUSH;
  logic [AW:0]   COUNT;
  logic          AFULL;
  logic          AEMPTY;
  logic          RAM_W_EN;
  logic [AW-1:0] RAM_W_ADDR;
  logic [DW-1:0] RAM_W_DATA;
  logic          RAM_R_EN;
  logic [AW-1:0] RAM_R_ADDR;
  logic [DW-1:0] RAM_R_DATA;
  occ_t          dbg_occ;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  int            cnt_m   = 0;
  bit            mon_en  = 1'b0;

  tpsram_fifo_ctrl dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .WR_DATA    (WR_DATA),
    .WR_VALID   (WR_VALID),
    .WR_READY   (WR_READY),
    .RD_DATA    (RD_DATA),
    .RD_VALID   (RD_VALID),
    .RD_READY   (RD_READY),
    .FLUSH      (FLUSH),
    .COUNT      (COUNT),
    .AFULL      (AFULL),
    .AEMPTY     (AEMPTY),
    .RAM_W_EN   (RAM_W_EN),
    .RAM_W_ADDR (RAM_W_ADDR),
    .RAM_W_DATA (RAM_W_DATA),
    .RAM_R_EN   (RAM_R_EN),
    .RAM_R_ADDR (RAM_R_ADDR),
    .RAM_R_DATA (RAM_R_DATA),
    .dbg_occ_o  (dbg_occ)
  );

  // ---------------- clock / SRAM model ----------------
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RAM_W_EN) mem[RAM_W_ADDR] <= RAM_W_DATA;
    if (RAM_R_EN) RAM_R_DATA <= mem[RAM_R_ADDR];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    step();
    WR_VALID = 1'b0;
    RD_READY = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (!RD_VALID && COUNT == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done", int'(done), 1);
    check("drain_queue_empty", exp_q.size(), 0);
    step();
    RD_READY = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (mon_en && RESETN) begin
      check("count_model", int'(COUNT), cnt_m);
      check("afull_model", int'(AFULL), int'(cnt_m >= 56));
      check("aempty_model", int'(AEMPTY), int'(cnt_m <= 8));
      if (RAM_R_EN && RAM_W_EN)
        check("raddr_vs_waddr_distinct", int'(RAM_R_ADDR != RAM_W_ADDR), 1);
      if (RD_VALID && RD_READY) begin
        if (exp_q.size() == 0) begin
          check("pop_with_empty_queue", int'(RD_DATA), -1);
        end else begin
          check("rd_data", int'(RD_DATA), int'(exp_q.pop_front()));
        end
        cnt_m--;
      end
      if (FLUSH) begin
        exp_q.delete();
        cnt_m = 0;
      end else if (WR_VALID && WR_READY) begin
        exp_q.push_back(WR_DATA);
        cnt_m++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int  acc, ren, sent, pops, gaps, maxc;
    bit  started, seen;

    RESETN   = 1'b0;
    WR_VALID = 1'b1;
    WR_DATA  = 20'h55555;
    RD_READY = 1'b0;
    FLUSH    = 1'b0;

    // Reset
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_wr_ready", int'(WR_READY), 0);
    check("rst_ram_w_en", int'(RAM_W_EN), 0);
    check("rst_ram_r_en", int'(RAM_R_EN), 0);
    check("rst_rd_valid", int'(RD_VALID), 0);
    check("rst_count", int'(COUNT), 0);
    check("rst_aempty", int'(AEMPTY), 1);
    check("rst_afull", int'(AFULL), 0);
    step();
    WR_VALID = 1'b0;
    #2;
    RESETN = 1'b1;
    mon_en = 1'b1;
    @(negedge CLK);
    check("release_wr_ready_before_edge", int'(WR_READY), 0);
    step();
    @(negedge CLK);
    check("release_wr_ready_after_edge", int'(WR_READY), 1);

    // Single word
    step();
    WR_VALID = 1'b1;
    WR_DATA  = 20'h12345;
    @(negedge CLK);
    check("single_w_en", int'(RAM_W_EN), 1);
    check("single_w_addr", int'(RAM_W_ADDR), 0);
    check("single_r_en_c0", int'(RAM_R_EN), 0);
    step();
    WR_VALID = 1'b0;
    @(negedge CLK);
    check("single_r_en_c1", int'(RAM_R_EN), 1);
    check("single_r_addr_c1", int'(RAM_R_ADDR), 0);
    step();
    @(negedge CLK);
    check("single_rd_valid_c2", int'(RD_VALID), 0);
    step();
    @(negedge CLK);
    check("single_rd_valid_c3", int'(RD_VALID), 1);
    check("single_rd_data_c3", int'(RD_DATA), 20'h12345);
    check("single_count_c3", int'(COUNT), 1);
    drain(20);

    // Fill
    acc = 0;
    ren = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      WR_VALID = 1'b1;
      WR_DATA  = 20'h40000 + DW'(acc);
      @(negedge CLK);
      if (WR_VALID && WR_READY) acc++;
      if (RAM_R_EN) ren++;
    end
    step();
    WR_VALID = 1'b0;
    @(negedge CLK);
    check("fill_accepted", acc, 66);
    check("fill_r_en_pulses", ren, 2);
    check("fill_wr_ready", int'(WR_READY), 0);
    check("fill_count", int'(COUNT), 66);
    check("fill_afull", int'(AFULL), 1);
    check("fill_aempty", int'(AEMPTY), 0);
    check("fill_occ_two", int'(dbg_occ), int'(OCC_TWO));
    check("fill_head", int'(RD_DATA), 20'h40000);
    drain(300);

    // Streaming
    sent = 0; pops = 0; gaps = 0; maxc = 0; started = 1'b0;
    for (int i = 0; i < 400 && pops < 200; i++) begin
      step();
      WR_VALID = (sent < 200);
      WR_DATA  = 20'h10000 + DW'(sent);
      RD_READY = 1'b1;
      @(negedge CLK);
      if (WR_VALID && WR_READY) sent++;
      if (RD_VALID && RD_READY) begin
        started = 1'b1;
        pops++;
      end else if (started && pops < 200) begin
        gaps++;
      end
      if (int'(COUNT) > maxc) maxc = int'(COUNT);
    end
    check("stream_sent", sent, 200);
    check("stream_pops", pops, 200);
    check("stream_gaps", gaps, 0);
    check("stream_max_count_le3", int'(maxc <= 3), 1);
    step();
    WR_VALID = 1'b0;
    RD_READY = 1'b0;
    @(negedge CLK);
    check("stream_count_end", int'(COUNT), 0);

    // Flush with a read in flight and a coincident pop
    for (int i = 0; i < 10; i++) begin
      step();
      WR_VALID = 1'b1;
      WR_DATA  = 20'h20000 + DW'(i);
    end
    step();
    WR_VALID = 1'b0;
    repeat (3) step();
    RD_READY = 1'b1;
    @(negedge CLK);
    check("flush_setup_read_issue", int'(RAM_R_EN), 1);
    step();
    FLUSH = 1'b1;
    @(negedge CLK);
    check("flush_wr_ready", int'(WR_READY), 0);
    check("flush_r_en", int'(RAM_R_EN), 0);
    check("flush_pop_word1", int'(RD_DATA), 20'h20001);
    step();
    FLUSH    = 1'b0;
    RD_READY = 1'b0;
    @(negedge CLK);
    check("flush_count", int'(COUNT), 0);
    check("flush_rd_valid", int'(RD_VALID), 0);
    step();
    WR_VALID = 1'b1;
    WR_DATA  = 20'hABCDE;
    @(negedge CLK);
    check("post_flush_w_addr", int'(RAM_W_ADDR), 0);
    step();
    WR_VALID = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (RD_VALID) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check("post_flush_valid_seen", int'(seen), 1);
    check("post_flush_rd_data", int'(RD_DATA), 20'hABCDE);
    drain(20);

    // Random backpressure
    for (int i = 0; i < 5000; i++) begin
      step();
      WR_VALID = 1'($urandom_range(0, 1));
      WR_DATA  = DW'($urandom_range(0, 20'hFFFFF));
      RD_READY = 1'($urandom_range(0, 1));
    end
    drain(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
